// File: rtl/rom_loader_pkg.sv
// Shared loader definitions: default geometry, frame header bytes, FSM states
// and the word-address helper used by the ROM write port.
package rom_loader_pkg;

   localparam int          DEF_ROM_WORDS      = 4096;
   localparam int          DEF_TIMEOUT_CYCLES = 1_000_000;
   localparam logic [7:0]  DEF_HDR0           = 8'h55;
   localparam logic [7:0]  DEF_HDR1           = 8'hAA;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HDR,
      ST_LEN_LO,
      ST_LEN_HI,
      ST_DATA,
      ST_CSUM
   } state_t;

   // Byte address of word idx, counted from base.
   function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [15:0] idx);
      return base + {14'd0, idx, 2'b00};
   endfunction

endpackage

// File: rtl/rom_loader_timeout.sv
// Inter-byte gap counter. Counts while enabled, clears on every received byte
// or when disabled, saturates at its last value and flags expiry there.
module rom_loader_timeout #(
   parameter int TIMEOUT_CYCLES = 1_000_000
) (
   input  logic sys_clk,
   input  logic sys_rst,
   input  logic clear,
   input  logic enable,
   output logic expire
);

   localparam int            CW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] cnt;

   // Gap counter: restart on a byte or outside a frame, otherwise count up to LAST and hold.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst)
         cnt <= '0;
      else if (clear || !enable)
         cnt <= '0;
      else if (cnt != LAST)
         cnt <= cnt + CW'(1);
   end

   // A byte arriving in the expiry cycle takes precedence over the abort.
   assign expire = enable && !clear && (cnt == LAST);

endmodule

// File: rtl/rom_loader.sv
// Serial boot loader: parses HDR0 HDR1 LEN_LO LEN_HI {LEN x 4 bytes} CSUM from
// the UART byte stream, writes little-endian words into the instruction ROM and
// holds the CPU in reset while a load is in progress.
module rom_loader
   import rom_loader_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
   parameter int          ROM_WORDS      = DEF_ROM_WORDS,
   parameter int          TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
   parameter logic [7:0]  HDR0           = DEF_HDR0,
   parameter logic [7:0]  HDR1           = DEF_HDR1
) (
   input  logic        sys_clk,
   input  logic        sys_rst,
   input  logic [7:0]  rx_data_i,
   input  logic        rx_valid_i,
   output logic        wr_en_o,
   output logic [31:0] wr_addr_o,
   output logic [31:0] wr_data_o,
   output logic        cpu_hold_o,
   output logic        load_done_o,
   output logic        load_err_o
);

   localparam logic [16:0] MAX_LEN = 17'(ROM_WORDS);

   state_t      state;
   logic [7:0]  len_lo;
   logic [15:0] len;
   logic [15:0] word_idx;
   logic [1:0]  byte_idx;
   logic [7:0]  csum;
   logic [23:0] word_buf;
   logic [15:0] len_w;
   logic        expire;

   assign len_w = {rx_data_i, len_lo};

   rom_loader_timeout #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timeout (
      .sys_clk(sys_clk),
      .sys_rst(sys_rst),
      .clear  (rx_valid_i),
      .enable (state != ST_IDLE),
      .expire (expire)
   );

   // Frame parser with registered outputs; advances only on received bytes or gap expiry.
   // NOTE: all state here uses non-blocking assignments so every branch sees pre-edge values.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state       <= ST_IDLE;
         len_lo      <= '0;
         len         <= '0;
         word_idx    <= '0;
         byte_idx    <= '0;
         csum        <= '0;
         word_buf    <= '0;
         wr_en_o     <= 1'b0;
         wr_addr_o   <= '0;
         wr_data_o   <= '0;
         cpu_hold_o  <= 1'b0;
         load_done_o <= 1'b0;
         load_err_o  <= 1'b0;
      end else begin
         wr_en_o     <= 1'b0;
         load_done_o <= 1'b0;
         if (rx_valid_i) begin
            case (state)
               ST_IDLE: begin
                  if (rx_data_i == HDR0) state <= ST_HDR;
               end
               ST_HDR: begin
                  if (rx_data_i == HDR1) begin
                     state      <= ST_LEN_LO;
                     cpu_hold_o <= 1'b1;
                     load_err_o <= 1'b0;
                  end else if (rx_data_i != HDR0) begin
                     state <= ST_IDLE;
                  end
               end
               ST_LEN_LO: begin
                  len_lo <= rx_data_i;
                  state  <= ST_LEN_HI;
               end
               ST_LEN_HI: begin
                  if (len_w == 16'd0 || {1'b0, len_w} > MAX_LEN) begin
                     state      <= ST_IDLE;
                     load_err_o <= 1'b1;
                     cpu_hold_o <= 1'b0;
                  end else begin
                     state    <= ST_DATA;
                     len      <= len_w;
                     word_idx <= '0;
                     byte_idx <= '0;
                     csum     <= '0;
                  end
               end
               ST_DATA: begin
                  csum     <= csum + rx_data_i;
                  byte_idx <= byte_idx + 2'd1;
                  case (byte_idx)
                     2'd0: word_buf[7:0]   <= rx_data_i;
                     2'd1: word_buf[15:8]  <= rx_data_i;
                     2'd2: word_buf[23:16] <= rx_data_i;
                     default: begin
                        wr_en_o   <= 1'b1;
                        wr_addr_o <= word_addr(BASE_ADDR, word_idx);
                        wr_data_o <= {rx_data_i, word_buf};
                        word_idx  <= word_idx + 16'd1;
                        if (word_idx + 16'd1 == len) state <= ST_CSUM;
                     end
                  endcase
               end
               ST_CSUM: begin
                  if (rx_data_i == csum) load_done_o <= 1'b1;
                  else                   load_err_o  <= 1'b1;
                  state      <= ST_IDLE;
                  cpu_hold_o <= 1'b0;
               end
               default: state <= ST_IDLE;
            endcase
         end else if (expire) begin
            state      <= ST_IDLE;
            load_err_o <= 1'b1;
            cpu_hold_o <= 1'b0;
         end
      end
   end

endmodule
